decode_control: RTL and testbench
=================================

# decode_control

Control stage directly downstream of the instruction fetch register in the 4-bit nibble processor. It consumes the fetched opcode/operand nibbles and the ALU carry/zero outputs, runs the fetch/execute phase machine, and holds the architectural C/Z flags. It drives every datapath strobe: program counter increment/load, fetch enable, accumulator enable, bus output enables, and the ALU select.

## Interface
- ADDR_W, 12, program counter / ROM address width
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- INSTR  in  4  opcode nibble (fetch register Q1)
- OPRND  in  4  operand nibble (fetch register Q2)
- PROG_BYTE  in  8  current ROM output, used as the jump low byte
- C_IN, ZERO_IN  in  1 each  combinational ALU carry/zero
- FETCH_EN  out  1  fetch register enable
- PC_INC  out  1  counter count enable
- PC_LOAD  out  1  counter load
- PC_TARGET  out  ADDR_W  counter load value
- ACC_EN  out  1  accumulator enable
- OPRND_OE  out  1  drive OPRND onto the ALU A bus
- IN_OE  out  1  drive the input port onto the ALU A bus
- ACC_OE  out  1  output-bus driver enable
- OUT_WE  out  1  one-cycle output-port write strobe
- ALU_SEL  out  3  ALU function select
- C_FLAG, Z_FLAG  out  1 each  registered flags
- HALTED  out  1  in HALT state

## Operation
- States: FETCH, EXEC, ADDR, HALT. Any illegal state encoding goes to FETCH.
- FETCH: FETCH_EN=1, PC_INC=1, so the fetch register captures ROM[PC] and PC advances. Next state is EXEC.
- EXEC: decodes INSTR. All strobes are asserted in this single cycle.
  - 0x0 NOP: no strobes. Next FETCH.
  - 0x1 LIT: OPRND_OE, ALU_SEL=000, ACC_EN.
  - 0x2 ADDI: OPRND_OE, ALU_SEL=011, ACC_EN, flags update.
  - 0x3 SUBI: OPRND_OE, ALU_SEL=001, ACC_EN, flags update.
  - 0x4 NANDI: OPRND_OE, ALU_SEL=100, ACC_EN. Flags are unchanged.
  - 0x5 CMPI: OPRND_OE, ALU_SEL=001. No ACC_EN; flags update.
  - 0x6 OUT: ALU_SEL=010, ACC_OE, OUT_WE.
  - 0x7 IN: IN_OE, ALU_SEL=000, ACC_EN.
  - 0x8 JMP, 0x9 JC, 0xA JNC, 0xB JZ, 0xC JNZ: no strobes. Next state is ADDR.
  - 0xD and 0xE are reserved and execute as NOP.
  - 0xF HALT: next state is HALT.
- ADDR: PROG_BYTE is ROM[PC], the jump low byte.
  - PC_TARGET = {OPRND, PROG_BYTE}, driven in every state.
  - If the condition is true (JMP is unconditional): PC_LOAD=1, PC_INC=0.
  - If false: PC_INC=1 to skip the address byte.
  - Next state is FETCH in both cases.
- Flags update: C_FLAG<=C_IN and Z_FLAG<=ZERO_IN at the end of the EXEC cycle for ADDI/SUBI/CMPI only.
- Jump conditions read the registered flags, never C_IN/ZERO_IN.
- HALT: all strobes are 0 and HALTED=1. HALT is left only by RST.
- Invariants:
  - OPRND_OE and IN_OE are never both 1.
  - PC_INC and PC_LOAD are never both 1.
  - ALU_SEL=010 in every state and opcode not listed above.

## Timing
- Control outputs are combinational from the state register, INSTR, and the flags. State and flags change only on the CLK rising edge.
- While RST=1, every strobe is forced to 0 in that same cycle, regardless of state.
- At the RST edge: state becomes FETCH and C_FLAG=Z_FLAG=0. HALTED=0 and ALU_SEL=010 during and after reset.
- First cycle after RST deasserts is FETCH.
- Cycle costs:
  - 1-byte instruction: 2 cycles (FETCH, EXEC).
  - Jump: 3 cycles (FETCH, EXEC, ADDR).
  - Data written by ACC_EN, and flags, are visible from the next cycle.
- A flag-setting instruction followed directly by a jump: the jump sees the new flags, since the update happens two cycles before ADDR.
- RST asserted in any state, including mid-jump in ADDR: no PC_LOAD is issued, and the jump is abandoned.
- Branch target wraps naturally within 12 bits. No special handling of 0xFFF.

## Structure
- Shared package `proc_pkg` holds:
  - opcode constants OP_NOP through OP_HALT;
  - state encoding (2 bits);
  - ALU select constants ALU_PASS_A=000, ALU_PASS_B=010, ALU_NAND=100, ALU_SUB=001, ALU_ADD=011.
- One sub-module, `jump_cond`: combinational, takes INSTR, C_FLAG, Z_FLAG and outputs `take`.
- The state register, flag register, and output decode stay in `decode_control`.

## Test plan
- Reset and LIT:
  - Stimulus: RST for 2 cycles, then INSTR=1, OPRND=5.
  - Required: strobes are 0 during reset. Cycle 1 has FETCH_EN=PC_INC=1. Cycle 2 has OPRND_OE=ACC_EN=1 and ALU_SEL=000.
- ADDI carry:
  - Stimulus: ADDI with C_IN=1, ZERO_IN=1 during EXEC.
  - Required: ALU_SEL=011, and C_FLAG=Z_FLAG=1 on the next cycle.
  - A following NANDI leaves both flags at 1.
- JC taken:
  - Stimulus: C_FLAG=1, INSTR=9, OPRND=0xA, PROG_BYTE=0x3C.
  - Required: in ADDR, PC_LOAD=1, PC_TARGET=0xA3C, PC_INC=0.
- JNZ not taken:
  - Stimulus: Z_FLAG=1, INSTR=0xC.
  - Required: in ADDR, PC_LOAD=0 and PC_INC=1; the next state is FETCH.
- CMPI then OUT:
  - CMPI: ACC_EN=0 and the flags update.
  - OUT: ACC_OE=OUT_WE=1 for exactly one cycle, ALU_SEL=010.
- HALT and mid-jump reset:
  - HALT: HALTED stays 1 and strobes stay 0 for 10 cycles; RST then returns the block to FETCH.
  - Mid-jump reset: RST in ADDR produces no PC_LOAD pulse.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared opcode, state and ALU select definitions for the nibble processor.
package proc_pkg;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ALU_W  = 3;

   // Opcode nibbles.
   localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
   localparam logic [OP_W-1:0] OP_LIT   = 4'h1;
   localparam logic [OP_W-1:0] OP_ADDI  = 4'h2;
   localparam logic [OP_W-1:0] OP_SUBI  = 4'h3;
   localparam logic [OP_W-1:0] OP_NANDI = 4'h4;
   localparam logic [OP_W-1:0] OP_CMPI  = 4'h5;
   localparam logic [OP_W-1:0] OP_OUT   = 4'h6;
   localparam logic [OP_W-1:0] OP_IN    = 4'h7;
   localparam logic [OP_W-1:0] OP_JMP   = 4'h8;
   localparam logic [OP_W-1:0] OP_JC    = 4'h9;
   localparam logic [OP_W-1:0] OP_JNC   = 4'hA;
   localparam logic [OP_W-1:0] OP_JZ    = 4'hB;
   localparam logic [OP_W-1:0] OP_JNZ   = 4'hC;
   localparam logic [OP_W-1:0] OP_RSV0  = 4'hD;
   localparam logic [OP_W-1:0] OP_RSV1  = 4'hE;
   localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

   // ALU function selects.
   localparam logic [ALU_W-1:0] ALU_PASS_A = 3'b000;
   localparam logic [ALU_W-1:0] ALU_SUB    = 3'b001;
   localparam logic [ALU_W-1:0] ALU_PASS_B = 3'b010;
   localparam logic [ALU_W-1:0] ALU_ADD    = 3'b011;
   localparam logic [ALU_W-1:0] ALU_NAND   = 3'b100;

   // Phase machine encoding.
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_ADDR  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   // Opcodes that occupy a second (address) byte.
   function automatic logic is_jump(input logic [OP_W-1:0] op);
      return (op >= OP_JMP) && (op <= OP_JNZ);
   endfunction

   // Opcodes whose ALU result latches C/Z.
   function automatic logic sets_flags(input logic [OP_W-1:0] op);
      return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);
   endfunction

endpackage

// File: rtl/decode_control_if.sv
// Fetch-register / ALU / datapath-strobe bundle around the control stage.
interface decode_control_if;
   import proc_pkg::*;

   logic [OP_W-1:0]   INSTR;
   logic [OP_W-1:0]   OPRND;
   logic [BYTE_W-1:0] PROG_BYTE;
   logic              C_IN;
   logic              ZERO_IN;

   logic              FETCH_EN;
   logic              PC_INC;
   logic              PC_LOAD;
   logic [ADDR_W-1:0] PC_TARGET;
   logic              ACC_EN;
   logic              OPRND_OE;
   logic              IN_OE;
   logic              ACC_OE;
   logic              OUT_WE;
   logic [ALU_W-1:0]  ALU_SEL;
   logic              C_FLAG;
   logic              Z_FLAG;
   logic              HALTED;

   // Control stage side.
   modport master (
      input  INSTR, OPRND, PROG_BYTE, C_IN, ZERO_IN,
      output FETCH_EN, PC_INC, PC_LOAD, PC_TARGET, ACC_EN, OPRND_OE, IN_OE,
             ACC_OE, OUT_WE, ALU_SEL, C_FLAG, Z_FLAG, HALTED
   );

   // Datapath side.
   modport slave (
      output INSTR, OPRND, PROG_BYTE, C_IN, ZERO_IN,
      input  FETCH_EN, PC_INC, PC_LOAD, PC_TARGET, ACC_EN, OPRND_OE, IN_OE,
             ACC_OE, OUT_WE, ALU_SEL, C_FLAG, Z_FLAG, HALTED
   );

endinterface

// File: rtl/decode_control_jump_cond.sv
// Jump condition evaluation against the architectural flags.
module jump_cond
   import proc_pkg::*;
(
   input  logic [OP_W-1:0] INSTR,
   input  logic            C_FLAG,
   input  logic            Z_FLAG,
   output logic            take
);

   // Non-jump opcodes never take.
   always_comb begin
      take = 1'b0;
      case (INSTR)
         OP_JMP:  take = 1'b1;
         OP_JC:   take = C_FLAG;
         OP_JNC:  take = ~C_FLAG;
         OP_JZ:   take = Z_FLAG;
         OP_JNZ:  take = ~Z_FLAG;
         default: take = 1'b0;
      endcase
   end

endmodule

// File: rtl/decode_control.sv
// Fetch/execute phase machine, C/Z flag register and datapath strobe decode.
module decode_control
   import proc_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   decode_control_if.master  bus
);

   state_t            state;
   state_t            state_nxt;
   logic              c_flag;
   logic              z_flag;
   logic              flag_we;
   logic              take;

   logic              fetch_en;
   logic              pc_inc;
   logic              pc_load;
   logic              acc_en;
   logic              oprnd_oe;
   logic              in_oe;
   logic              acc_oe;
   logic              out_we;
   logic [ALU_W-1:0]  alu_sel;
   logic              halted;

   jump_cond u_jump_cond (
      .INSTR  (bus.INSTR),
      .C_FLAG (c_flag),
      .Z_FLAG (z_flag),
      .take   (take)
   );

   // State and flag registers; flags latch only at the end of a flag-setting EXEC.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= ST_FETCH;
         c_flag <= 1'b0;
         z_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         if (flag_we) begin
            c_flag <= bus.C_IN;
            z_flag <= bus.ZERO_IN;
         end
      end
   end

   // Next state and strobe decode; reset overrides every strobe in the same cycle.
   always_comb begin
      state_nxt = state;
      flag_we   = 1'b0;
      fetch_en  = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      acc_en    = 1'b0;
      oprnd_oe  = 1'b0;
      in_oe     = 1'b0;
      acc_oe    = 1'b0;
      out_we    = 1'b0;
      alu_sel   = ALU_PASS_B;
      halted    = 1'b0;

      case (state)
         ST_FETCH: begin
            fetch_en  = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = ST_EXEC;
         end

         ST_EXEC: begin
            state_nxt = ST_FETCH;
            flag_we   = sets_flags(bus.INSTR);
            case (bus.INSTR)
               OP_LIT: begin
                  oprnd_oe = 1'b1;
                  alu_sel  = ALU_PASS_A;
                  acc_en   = 1'b1;
               end
               OP_ADDI: begin
                  oprnd_oe = 1'b1;
                  alu_sel  = ALU_ADD;
                  acc_en   = 1'b1;
               end
               OP_SUBI: begin
                  oprnd_oe = 1'b1;
                  alu_sel  = ALU_SUB;
                  acc_en   = 1'b1;
               end
               OP_NANDI: begin
                  oprnd_oe = 1'b1;
                  alu_sel  = ALU_NAND;
                  acc_en   = 1'b1;
               end
               OP_CMPI: begin
                  oprnd_oe = 1'b1;
                  alu_sel  = ALU_SUB;
               end
               OP_OUT: begin
                  alu_sel = ALU_PASS_B;
                  acc_oe  = 1'b1;
                  out_we  = 1'b1;
               end
               OP_IN: begin
                  in_oe   = 1'b1;
                  alu_sel = ALU_PASS_A;
                  acc_en  = 1'b1;
               end
               OP_HALT: state_nxt = ST_HALT;
               default: begin
                  if (is_jump(bus.INSTR)) begin
                     state_nxt = ST_ADDR;
                  end
               end
            endcase
         end

         ST_ADDR: begin
            // Taken jumps load the target; otherwise step over the address byte.
            pc_load   = take;
            pc_inc    = ~take;
            state_nxt = ST_FETCH;
         end

         ST_HALT: begin
            halted    = 1'b1;
            state_nxt = ST_HALT;
         end

         default: state_nxt = ST_FETCH;
      endcase

      if (RST) begin
         flag_we  = 1'b0;
         fetch_en = 1'b0;
         pc_inc   = 1'b0;
         pc_load  = 1'b0;
         acc_en   = 1'b0;
         oprnd_oe = 1'b0;
         in_oe    = 1'b0;
         acc_oe   = 1'b0;
         out_we   = 1'b0;
         alu_sel  = ALU_PASS_B;
         halted   = 1'b0;
      end
   end

   // Jump target is always presented; only PC_LOAD decides whether it is used.
   assign bus.PC_TARGET = {bus.OPRND, bus.PROG_BYTE};
   assign bus.FETCH_EN  = fetch_en;
   assign bus.PC_INC    = pc_inc;
   assign bus.PC_LOAD   = pc_load;
   assign bus.ACC_EN    = acc_en;
   assign bus.OPRND_OE  = oprnd_oe;
   assign bus.IN_OE     = in_oe;
   assign bus.ACC_OE    = acc_oe;
   assign bus.OUT_WE    = out_we;
   assign bus.ALU_SEL   = alu_sel;
   assign bus.C_FLAG    = c_flag;
   assign bus.Z_FLAG    = z_flag;
   assign bus.HALTED    = halted;

endmodule

// File: tb/tb_decode_control.sv
// Instruction-level bench for decode_control: an expected-cycle queue built per instruction.
module tb_decode_control;

   typedef struct packed {
      logic        fetch_en;
      logic        pc_inc;
      logic        pc_load;
      logic [11:0] pc_target;
      logic        acc_en;
      logic        oprnd_oe;
      logic        in_oe;
      logic        acc_oe;
      logic        out_we;
      logic [2:0]  alu_sel;
      logic        c_flag;
      logic        z_flag;
      logic        halted;
   } exp_t;

   logic CLK;
   logic RST;

   decode_control_if bus ();

   decode_control dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   exp_t  exp_q[$];
   string lbl_q[$];
   int    n_checks = 0;
   int    n_err    = 0;

   // Architectural flags as the program sees them.
   logic  m_c = 1'b0;
   logic  m_z = 1'b0;

   function automatic exp_t base();
      exp_t e;
      e           = '0;
      e.alu_sel   = 3'b010;
      e.pc_target = {bus.OPRND, bus.PROG_BYTE};
      e.c_flag    = m_c;
      e.z_flag    = m_z;
      return e;
   endfunction

   // Queue one cycle's expectation, then advance to just after the next rising edge.
   task automatic cyc(input exp_t e, input string l);
      exp_q.push_back(e);
      lbl_q.push_back(l);
      @(posedge CLK);
      #1;
   endtask

   // One instruction: FETCH, EXEC and, for jumps, ADDR.
   task automatic instr(input logic [3:0] op, input logic [3:0] opr, input logic [7:0] pb,
                        input logic cin, input logic zin, input string name);
      exp_t e;
      logic take;
      bus.INSTR     = op;
      bus.OPRND     = opr;
      bus.PROG_BYTE = pb;
      bus.C_IN      = cin;
      bus.ZERO_IN   = zin;
      RST           = 1'b0;

      e = base(); e.fetch_en = 1'b1; e.pc_inc = 1'b1;
      cyc(e, {name, "_fetch"});

      e = base();
      case (op)
         4'h1: begin e.oprnd_oe = 1; e.alu_sel = 3'b000; e.acc_en = 1; end
         4'h2: begin e.oprnd_oe = 1; e.alu_sel = 3'b011; e.acc_en = 1; end
         4'h3: begin e.oprnd_oe = 1; e.alu_sel = 3'b001; e.acc_en = 1; end
         4'h4: begin e.oprnd_oe = 1; e.alu_sel = 3'b100; e.acc_en = 1; end
         4'h5: begin e.oprnd_oe = 1; e.alu_sel = 3'b001; end
         4'h6: begin e.acc_oe = 1; e.out_we = 1; end
         4'h7: begin e.in_oe = 1; e.alu_sel = 3'b000; e.acc_en = 1; end
         default: ;
      endcase
      cyc(e, {name, "_exec"});
      if (op == 4'h2 || op == 4'h3 || op == 4'h5) begin
         m_c = cin;
         m_z = zin;
      end

      if (op >= 4'h8 && op <= 4'hC) begin
         case (op)
            4'h8:    take = 1'b1;
            4'h9:    take = m_c;
            4'hA:    take = !m_c;
            4'hB:    take = m_z;
            default: take = !m_z;
         endcase
         e = base(); e.pc_load = take; e.pc_inc = !take;
         cyc(e, {name, "_addr"});
      end
   endtask

   task automatic do_reset(input string name, input int n);
      exp_t e;
      RST = 1'b1;
      for (int i = 0; i < n; i++) begin
         e = base();
         cyc(e, name);
         m_c = 1'b0;
         m_z = 1'b0;
      end
      RST = 1'b0;
   endtask

   task automatic lit(input string name, input logic act, input logic want);
      n_checks++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0b want %0b", name, act, want);
      end
   endtask

   // Single checker: full output vector each cycle, invariants, and literal pins.
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         exp_t  a;
         string l;
         e = exp_q.pop_front();
         l = lbl_q.pop_front();
         a.fetch_en  = bus.FETCH_EN;
         a.pc_inc    = bus.PC_INC;
         a.pc_load   = bus.PC_LOAD;
         a.pc_target = bus.PC_TARGET;
         a.acc_en    = bus.ACC_EN;
         a.oprnd_oe  = bus.OPRND_OE;
         a.in_oe     = bus.IN_OE;
         a.acc_oe    = bus.ACC_OE;
         a.out_we    = bus.OUT_WE;
         a.alu_sel   = bus.ALU_SEL;
         a.c_flag    = bus.C_FLAG;
         a.z_flag    = bus.Z_FLAG;
         a.halted    = bus.HALTED;

         n_checks++;
         if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h want %h", l, a, e);
         end
         n_checks++;
         if ((bus.OPRND_OE & bus.IN_OE) !== 1'b0 || (bus.PC_INC & bus.PC_LOAD) !== 1'b0) begin
            n_err++;
            $display("FAIL %s_excl: oe=%0b%0b pc=%0b%0b want no overlap",
                     l, bus.OPRND_OE, bus.IN_OE, bus.PC_INC, bus.PC_LOAD);
         end

         if (l == "rst") begin
            lit("rst_fetch_en", bus.FETCH_EN, 1'b0);
            lit("rst_halted", bus.HALTED, 1'b0);
            lit("rst_alu_b", bus.ALU_SEL == 3'b010, 1'b1);
         end
         if (l == "lit_fetch") lit("lit_fetch_pcinc", bus.FETCH_EN & bus.PC_INC, 1'b1);
         if (l == "lit_exec") begin
            lit("lit_oe_acc", bus.OPRND_OE & bus.ACC_EN, 1'b1);
            lit("lit_alu_a", bus.ALU_SEL == 3'b000, 1'b1);
         end
         if (l == "addi_exec") lit("addi_alu", bus.ALU_SEL == 3'b011, 1'b1);
         if (l == "nandi_exec") lit("nandi_flags", bus.C_FLAG & bus.Z_FLAG, 1'b1);
         if (l == "nandi2_fetch") lit("after_nandi_flags", bus.C_FLAG & bus.Z_FLAG, 1'b1);
         if (l == "jc_addr") begin
            lit("jc_target", bus.PC_TARGET == 12'hA3C, 1'b1);
            lit("jc_load", bus.PC_LOAD, 1'b1);
            lit("jc_noinc", bus.PC_INC, 1'b0);
         end
         if (l == "jnz_addr") begin
            lit("jnz_load", bus.PC_LOAD, 1'b0);
            lit("jnz_inc", bus.PC_INC, 1'b1);
         end
         if (l == "cmpi_exec") lit("cmpi_noacc", bus.ACC_EN, 1'b0);
         if (l == "out_exec") begin
            lit("out_strobes", bus.ACC_OE & bus.OUT_WE, 1'b1);
            lit("out_alu", bus.ALU_SEL == 3'b010, 1'b1);
         end
         if (l == "out2_fetch") lit("out_one_cycle", bus.OUT_WE, 1'b0);
         if (l == "halt_wait") lit("halt_halted", bus.HALTED, 1'b1);
         if (l == "midrst") lit("midrst_noload", bus.PC_LOAD, 1'b0);
      end
   end

   initial begin
      exp_t e;
      RST           = 1'b1;
      bus.INSTR     = 4'h0;
      bus.OPRND     = 4'h0;
      bus.PROG_BYTE = 8'h00;
      bus.C_IN      = 1'b0;
      bus.ZERO_IN   = 1'b0;
      @(posedge CLK);
      #1;

      do_reset("rst", 2);
      instr(4'h1, 4'h5, 8'h00, 1'b0, 1'b0, "lit");
      instr(4'h2, 4'h7, 8'h11, 1'b1, 1'b1, "addi");
      instr(4'h4, 4'h3, 8'h22, 1'b0, 1'b0, "nandi");
      instr(4'h0, 4'h0, 8'h00, 1'b0, 1'b0, "nandi2");
      instr(4'h9, 4'hA, 8'h3C, 1'b0, 1'b0, "jc");
      instr(4'hC, 4'h1, 8'h80, 1'b0, 1'b0, "jnz");
      instr(4'h5, 4'h2, 8'h00, 1'b0, 1'b0, "cmpi");
      instr(4'h6, 4'h0, 8'h00, 1'b1, 1'b1, "out");
      instr(4'h0, 4'h0, 8'h00, 1'b0, 1'b0, "out2");
      instr(4'h9, 4'h4, 8'h44, 1'b0, 1'b0, "jc_nt");
      instr(4'hA, 4'h5, 8'h55, 1'b0, 1'b0, "jnc");
      instr(4'h7, 4'h0, 8'h00, 1'b0, 1'b0, "in");
      instr(4'h3, 4'h1, 8'h00, 1'b1, 1'b0, "subi");
      instr(4'h9, 4'h6, 8'h66, 1'b0, 1'b0, "jc_new");
      instr(4'hB, 4'h7, 8'h77, 1'b0, 1'b0, "jz_nt");
      instr(4'h8, 4'hF, 8'hFF, 1'b0, 1'b0, "jmp_fff");
      instr(4'hD, 4'h9, 8'h00, 1'b1, 1'b1, "rsv_d");
      instr(4'hE, 4'h9, 8'h00, 1'b1, 1'b1, "rsv_e");
      instr(4'hF, 4'h0, 8'h00, 1'b0, 1'b0, "halt");
      for (int i = 0; i < 10; i++) begin
         e = base(); e.halted = 1'b1;
         cyc(e, "halt_wait");
      end
      do_reset("halt_rst", 1);
      instr(4'h1, 4'h2, 8'h00, 1'b0, 1'b0, "lit2");

      // Jump abandoned by reset while in ADDR.
      instr(4'h2, 4'h1, 8'h00, 1'b0, 1'b1, "addi_z");
      bus.INSTR     = 4'h8;
      bus.OPRND     = 4'h3;
      bus.PROG_BYTE = 8'h21;
      e = base(); e.fetch_en = 1'b1; e.pc_inc = 1'b1;
      cyc(e, "mj_fetch");
      e = base();
      cyc(e, "mj_exec");
      do_reset("midrst", 1);
      instr(4'hB, 4'h0, 8'h10, 1'b0, 1'b0, "jz_after_rst");

      @(posedge CLK);
      @(posedge CLK);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
